// File: rtl/fns_dec_seq.sv
// Sequential Fibonacci-numeral-system decoder: masks a codeword and sums F(i+1) weights DPC digits per clock.
// Accept at edge t, result valid from edge t+NCH; held stable under out_ready=0.
module fns_dec_seq #(
  parameter int CW  = 9,
  parameter int BW  = 7,
  parameter int DPC = 3
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          in_valid,
  output logic          in_ready,
  input  logic [CW-1:0] codein,
  input  logic [CW-1:0] en_flag,
  input  logic          clr,
  output logic          out_valid,
  input  logic          out_ready,
  output logic [BW-1:0] dataout,
  output logic          ovf
);

  // F(1)=F(2)=1
  function automatic int fib(input int n);
    int a, b, t;
    a = 1;
    b = 1;
    for (int i = 2; i < n; i++) begin
      t = a + b;
      a = b;
      b = t;
    end
    return b;
  endfunction

  localparam int AW  = $clog2(fib(CW + 2));
  localparam int NCH = (CW + DPC - 1) / DPC;
  localparam int PW  = NCH * DPC;
  localparam int IW  = (NCH > 1) ? $clog2(NCH) : 1;
  localparam int EW  = ((AW > BW) ? AW : BW) + 1;

  // Weight table padded with zeros so the last partial chunk needs no bounds logic
  function automatic logic [PW*AW-1:0] gen_wts();
    logic [PW*AW-1:0] r;
    r = '0;
    for (int i = 0; i < CW; i++) r[i*AW +: AW] = AW'(fib(i + 1));
    return r;
  endfunction

  localparam logic [PW*AW-1:0] WTS  = gen_wts();
  localparam logic [EW-1:0]    MAXV = (EW'(1) << BW) - EW'(1);

  typedef enum logic [1:0] {IDLE, ACC, DONE} state_t;

  state_t        state;
  logic [PW-1:0] masked;
  logic [AW-1:0] acc;
  logic [AW-1:0] next_acc;
  logic [IW-1:0] idx;
  logic [DPC-1:0] chunk;
  logic [EW-1:0] next_ext;

  always_comb begin
    chunk    = masked[int'(idx)*DPC +: DPC];
    next_acc = acc;
    for (int k = 0; k < DPC; k++) begin
      if (chunk[k]) next_acc = next_acc + WTS[(int'(idx)*DPC + k)*AW +: AW];
    end
    next_ext = EW'(next_acc);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= IDLE;
      in_ready  <= 1'b1;
      out_valid <= 1'b0;
      dataout   <= '0;
      ovf       <= 1'b0;
      acc       <= '0;
      idx       <= '0;
      masked    <= '0;
    end else if (clr) begin
      state     <= IDLE;
      in_ready  <= 1'b1;
      out_valid <= 1'b0;
      acc       <= '0;
      idx       <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (in_valid) begin
            masked   <= PW'(codein & en_flag);
            acc      <= '0;
            idx      <= '0;
            in_ready <= 1'b0;
            state    <= ACC;
          end
        end
        ACC: begin
          acc <= next_acc;
          idx <= idx + IW'(1);
          if (idx == IW'(NCH - 1)) begin
            state     <= DONE;
            out_valid <= 1'b1;
            ovf       <= (next_ext > MAXV);
            dataout   <= (next_ext > MAXV) ? {BW{1'b1}} : next_ext[BW-1:0];
          end
        end
        DONE: begin
          if (out_ready) begin
            state     <= IDLE;
            out_valid <= 1'b0;
            in_ready  <= 1'b1;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_fns_dec_seq.sv
// Bench for fns_dec_seq: two lockstep instances (BW=7, BW=6) on directed steps, plus a CW=12/DPC=5 random run.
module tb_fns_dec_seq;
  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic       rst, in_valid, clr, out_ready;
  logic [8:0] codein, en_flag;
  logic       in_ready, out_valid, ovf;
  logic [6:0] dataout;
  logic       in_ready6, out_valid6, ovf6;
  logic [5:0] dataout6;

  logic        r_in_valid, r_in_ready, r_out_valid, r_out_ready, r_ovf, r_clr;
  logic [11:0] r_code, r_en;
  logic [7:0]  r_data;

  int errors = 0;
  int checks = 0;
  int q7[$], q6[$], qr[$];

  fns_dec_seq #(.CW(9), .BW(7), .DPC(3)) dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready), .codein(codein),
    .en_flag(en_flag), .clr(clr), .out_valid(out_valid), .out_ready(out_ready),
    .dataout(dataout), .ovf(ovf));

  fns_dec_seq #(.CW(9), .BW(6), .DPC(3)) dut6 (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready6), .codein(codein),
    .en_flag(en_flag), .clr(clr), .out_valid(out_valid6), .out_ready(out_ready),
    .dataout(dataout6), .ovf(ovf6));

  fns_dec_seq #(.CW(12), .BW(8), .DPC(5)) dut_r (
    .clk(clk), .rst(rst), .in_valid(r_in_valid), .in_ready(r_in_ready), .codein(r_code),
    .en_flag(r_en), .clr(r_clr), .out_valid(r_out_valid), .out_ready(r_out_ready),
    .dataout(r_data), .ovf(r_ovf));

  // Plain weighted sum, weights 1,1,2,3,5,...
  function automatic int ref_sum(input logic [31:0] m, input int cw);
    int a, b, t, s;
    a = 1; b = 1; s = 0;
    for (int i = 0; i < cw; i++) begin
      if (m[i]) s += a;
      t = a + b; a = b; b = t;
    end
    return s;
  endfunction

  // Expected result packed as {ovf, data}
  function automatic int pack_exp(input int s, input int bw);
    int maxv;
    maxv = (1 << bw) - 1;
    return (s > maxv) ? ((1 << 16) | maxv) : s;
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic send(input logic [8:0] c, input logic [8:0] e);
    int n;
    n = 0;
    while (!in_ready && n < 50) begin @(posedge clk); #1; n++; end
    chk("in_ready_idle", in_ready, 1);
    codein = c; en_flag = e; in_valid = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0;
    codein = 9'($urandom); en_flag = 9'($urandom);
    q7.push_back(pack_exp(ref_sum(32'(c & e), 9), 7));
    q6.push_back(pack_exp(ref_sum(32'(c & e), 9), 6));
    chk("in_ready_busy", in_ready, 0);
  endtask

  task automatic recv(input int hold);
    int lat, e7, e6;
    lat = 0;
    while (!out_valid && lat < 20) begin @(posedge clk); #1; lat++; end
    chk("latency", lat, 3);
    e7 = q7.pop_front();
    e6 = q6.pop_front();
    chk("dataout", dataout, e7 & 16'hFFFF);
    chk("ovf", ovf, e7 >> 16);
    chk("out_valid6", out_valid6, 1);
    chk("dataout6", dataout6, e6 & 16'hFFFF);
    chk("ovf6", ovf6, e6 >> 16);
    for (int h = 0; h < hold; h++) begin
      in_valid = 1'b1; codein = 9'($urandom); en_flag = 9'h1FF;
      @(posedge clk); #1;
      chk("bp_out_valid", out_valid, 1);
      chk("bp_in_ready", in_ready, 0);
      chk("bp_dataout", dataout, e7 & 16'hFFFF);
      chk("bp_ovf", ovf, e7 >> 16);
    end
    in_valid = 1'b0;
    out_ready = 1'b1;
    @(posedge clk); #1;
    out_ready = 1'b0;
    chk("out_valid_drop", out_valid, 0);
    chk("in_ready_back", in_ready, 1);
  endtask

  initial begin
    int lat, ex, n;
    rst = 1'b1; in_valid = 1'b0; clr = 1'b0; out_ready = 1'b0; codein = '0; en_flag = '0;
    r_in_valid = 1'b0; r_out_ready = 1'b0; r_clr = 1'b0; r_code = '0; r_en = '0;
    repeat (2) @(posedge clk);
    #1;
    chk("rst_in_ready", in_ready, 1);
    chk("rst_out_valid", out_valid, 0);
    chk("rst_dataout", dataout, 0);
    chk("rst_ovf", ovf, 0);
    rst = 1'b0;
    @(posedge clk); #1;

    send(9'h1FF, 9'h1FF); recv(0);   // 88 / sat 63
    send(9'h101, 9'h1FF); recv(0);   // 35
    send(9'h1FF, 9'h0FF); recv(5);   // 54 under backpressure
    send(9'h1FF, 9'h000); recv(0);   // 0
    send(9'h0FF, 9'h1FF); recv(0);   // 54, no ovf at BW=6

    // clr beats in_valid in IDLE
    in_valid = 1'b1; clr = 1'b1; codein = 9'h1FF; en_flag = 9'h1FF;
    @(posedge clk); #1;
    in_valid = 1'b0; clr = 1'b0;
    chk("clr_idle_in_ready", in_ready, 1);
    for (int i = 0; i < 4; i++) begin
      @(posedge clk); #1;
      chk("clr_idle_no_out", out_valid, 0);
    end

    // clr during the second ACC cycle
    send(9'h1FF, 9'h1FF);
    @(posedge clk); #1;
    clr = 1'b1;
    @(posedge clk); #1;
    clr = 1'b0;
    void'(q7.pop_back()); void'(q6.pop_back());
    chk("clr_acc_in_ready", in_ready, 1);
    for (int i = 0; i < 4; i++) begin
      chk("clr_acc_no_out", out_valid, 0);
      @(posedge clk); #1;
    end
    send(9'h003, 9'h1FF); recv(0);   // 2

    // async reset mid-ACC
    send(9'h1FF, 9'h1FF);
    @(posedge clk); #1;
    rst = 1'b1;
    #1;
    chk("arst_in_ready", in_ready, 1);
    chk("arst_out_valid", out_valid, 0);
    chk("arst_dataout", dataout, 0);
    chk("arst_ovf", ovf, 0);
    chk("arst_dataout6", dataout6, 0);
    void'(q7.pop_back()); void'(q6.pop_back());
    #1;
    rst = 1'b0;
    @(posedge clk); #1;

    // Random run on CW=12, DPC=5 (padded last chunk), BW=8
    for (int it = 0; it < 40; it++) begin
      r_code = (it == 0) ? 12'hFFF : 12'($urandom);
      r_en   = (it == 0 || it[0]) ? 12'hFFF : 12'($urandom);
      n = 0;
      while (!r_in_ready && n < 50) begin @(posedge clk); #1; n++; end
      chk("r_in_ready", r_in_ready, 1);
      r_in_valid = 1'b1;
      qr.push_back(pack_exp(ref_sum(32'(r_code & r_en), 12), 8));
      @(posedge clk); #1;
      r_in_valid = 1'b0;
      r_code = 12'($urandom);
      lat = 0;
      while (!r_out_valid && lat < 20) begin @(posedge clk); #1; lat++; end
      chk("r_latency", lat, 3);
      ex = qr.pop_front();
      chk("r_dataout", r_data, ex & 16'hFFFF);
      chk("r_ovf", r_ovf, ex >> 16);
      repeat ($urandom_range(0, 2)) begin @(posedge clk); #1; end
      r_out_ready = 1'b1;
      @(posedge clk); #1;
      r_out_ready = 1'b0;
      chk("r_out_drop", r_out_valid, 0);
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
